// File: rtl/sha2_msg_sched_param.sv
// SHA-2 message-schedule engine, parametrised for SHA-256 (32-bit words)
// or SHA-384/512 (64-bit words). It accepts one 16-word block over a
// valid/ready port and streams W0..W(ROUNDS-1) over a valid/ready word port.
//
// state | meaning
// IDLE  | waiting for a block; blk_ready_o high
// RUN   | streaming schedule words; w_valid_o high
module sha2_msg_sched_param #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = (WORD_W == 64) ? 80 : 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  blk_valid_i,
  output logic                  blk_ready_o,
  input  logic [16*WORD_W-1:0]  blk_data_i,
  input  logic                  abort_i,
  output logic                  w_valid_o,
  input  logic                  w_ready_i,
  output logic [WORD_W-1:0]     w_data_o,
  output logic [6:0]            w_idx_o,
  output logic                  w_last_o,
  output logic                  busy_o
);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("sha2_msg_sched_param: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
      $error("sha2_msg_sched_param: ROUNDS must be in 16..80");
    end
  endgenerate

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   win [16];
  logic [6:0]          t;
  logic [WORD_W-1:0]   new_word;
  logic                load_hs;
  logic                word_hs;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                              input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else              return rotr(x, 1) ^ rotr(x, 8)  ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    if (WORD_W == 32) return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else              return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // Next window word: single-cycle 4-operand sum, no pipelining.
  always_comb begin
    new_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  // abort_i masks the load handshake combinationally so a block offered
  // alongside an abort is never half-accepted.
  assign blk_ready_o = (state == IDLE) && !abort_i;
  assign w_valid_o   = (state == RUN);
  assign busy_o      = (state == RUN);
  assign w_data_o    = win[0];
  assign w_idx_o     = t;
  assign w_last_o    = (state == RUN) && (t == LAST_T);

  assign load_hs = blk_valid_i && blk_ready_o;
  assign word_hs = w_valid_o && w_ready_i;

  // FSM, round counter and sliding window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      t     <= '0;
      for (int k = 0; k < 16; k++) win[k] <= '0;
    end else if (abort_i) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_hs) begin
            for (int k = 0; k < 16; k++)
              win[k] <= blk_data_i[(15-k)*WORD_W +: WORD_W];
            t     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (word_hs) begin
            for (int k = 0; k < 15; k++) win[k] <= win[k+1];
            win[15] <= new_word;
            if (t == LAST_T) begin
              t     <= '0;
              state <= IDLE;
            end else begin
              t <= t + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_msg_sched_param.sv
// Directed bench for sha2_msg_sched_param: SHA-256 and SHA-512 "abc"
// schedules, backpressure, abort, async reset and back-to-back loads.
module tb_sha2_msg_sched_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // SHA-256 instance signals
  logic          blk_valid32 = 1'b0;
  logic          blk_ready32;
  logic [511:0]  blk_data32 = '0;
  logic          abort32 = 1'b0;
  logic          valid32;
  logic          ready32 = 1'b0;
  logic [31:0]   data32;
  logic [6:0]    idx32;
  logic          last32;
  logic          busy32;

  // SHA-512 instance signals
  logic          blk_valid64 = 1'b0;
  logic          blk_ready64;
  logic [1023:0] blk_data64 = '0;
  logic          abort64 = 1'b0;
  logic          valid64;
  logic          ready64 = 1'b0;
  logic [63:0]   data64;
  logic [6:0]    idx64;
  logic          last64;
  logic          busy64;

  sha2_msg_sched_param #(.WORD_W(32)) u_dut32 (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(blk_valid32), .blk_ready_o(blk_ready32), .blk_data_i(blk_data32),
    .abort_i(abort32),
    .w_valid_o(valid32), .w_ready_i(ready32), .w_data_o(data32),
    .w_idx_o(idx32), .w_last_o(last32), .busy_o(busy32)
  );

  sha2_msg_sched_param #(.WORD_W(64)) u_dut64 (
    .clk_i(clk), .rst_i(rst),
    .blk_valid_i(blk_valid64), .blk_ready_o(blk_ready64), .blk_data_i(blk_data64),
    .abort_i(abort64),
    .w_valid_o(valid64), .w_ready_i(ready64), .w_data_o(data64),
    .w_idx_o(idx64), .w_last_o(last64), .busy_o(busy64)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [511:0]  abc32;
  logic [1023:0] abc64;
  logic [31:0]   m32 [64];
  logic [63:0]   m64 [80];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference sigmas built from concatenation-based rotates.
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return ror32(x, 7) ^ ror32(x, 18) ^ {3'b000, x[31:3]};
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return ror32(x, 17) ^ ror32(x, 19) ^ {10'b0, x[31:10]};
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return ror64(x, 1) ^ ror64(x, 8) ^ {7'b0, x[63:7]};
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return ror64(x, 19) ^ ror64(x, 61) ^ {6'b0, x[63:6]};
  endfunction

  task automatic build_models();
    abc32 = {32'h61626380, {14{32'h0}}, 32'h00000018};
    abc64 = {64'h6162638000000000, {14{64'h0}}, 64'h18};
    for (int i = 0; i < 16; i++) begin
      m32[i] = abc32[(15-i)*32 +: 32];
      m64[i] = abc64[(15-i)*64 +: 64];
    end
    for (int i = 16; i < 64; i++)
      m32[i] = s1_32(m32[i-2]) + m32[i-7] + s0_32(m32[i-15]) + m32[i-16];
    for (int i = 16; i < 80; i++)
      m64[i] = s1_64(m64[i-2]) + m64[i-7] + s0_64(m64[i-15]) + m64[i-16];
  endtask

  task automatic load32();
    blk_data32  = abc32;
    blk_valid32 = 1'b1;
    step();
    blk_valid32 = 1'b0;
  endtask

  // Consumes words until index stop_at is presented (or the block ends).
  task automatic stream32(input int stall_pct, input int stop_at);
    int t = 0;
    int cyc = 0;
    bit hs;
    while (t < stop_at && cyc < 1000 && (n_checks - n_pass) < 40) begin
      check("w_valid", 64'(valid32), 64'd1);
      check("w_idx", 64'(idx32), 64'(t));
      check("w_data", 64'(data32), 64'(m32[t]));
      check("w_last", 64'(last32), 64'(t == 63));
      if (t == 0)  check("w0_const", 64'(data32), 64'h61626380);
      if (t == 15) check("w15_const", 64'(data32), 64'h00000018);
      if (t == 16) check("w16_const", 64'(data32), 64'h61626380);
      if (t == 17) check("w17_const", 64'(data32), 64'h000F0000);
      ready32 = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      hs = ready32 && valid32;
      step();
      if (hs) t++;
      cyc++;
    end
    ready32 = 1'b0;
    check("stream32_done", 64'(t), 64'(stop_at));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    build_models();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset values
    check("rst_blk_ready", 64'(blk_ready32), 64'd1);
    check("rst_w_valid", 64'(valid32), 64'd0);
    check("rst_w_data", 64'(data32), 64'd0);
    check("rst_w_idx", 64'(idx32), 64'd0);
    check("rst_w_last", 64'(last32), 64'd0);
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst64_w_data", data64, 64'd0);
    step();

    // SHA-256 "abc", no stalls
    load32();
    check("load_busy", 64'(busy32), 64'd1);
    check("load_blk_ready", 64'(blk_ready32), 64'd0);
    stream32(0, 64);
    check("end_w_valid", 64'(valid32), 64'd0);
    check("end_blk_ready", 64'(blk_ready32), 64'd1);
    check("end_w_last", 64'(last32), 64'd0);
    step();
    check("idle_blk_ready", 64'(blk_ready32), 64'd1);

    // Backpressure
    load32();
    stream32(50, 64);
    check("bp_end_w_valid", 64'(valid32), 64'd0);
    step();

    // Abort at index 20 with a block offered in the same cycle
    load32();
    stream32(0, 20);
    check("pre_abort_idx", 64'(idx32), 64'd20);
    abort32     = 1'b1;
    blk_valid32 = 1'b1;
    #1;
    check("abort_mask_ready", 64'(blk_ready32), 64'd0);
    step();
    abort32 = 1'b0;
    #1;
    check("abort_w_valid", 64'(valid32), 64'd0);
    check("abort_w_idx", 64'(idx32), 64'd0);
    check("abort_blk_ready", 64'(blk_ready32), 64'd1);
    step();
    blk_valid32 = 1'b0;
    check("post_abort_load", 64'(valid32), 64'd1);
    stream32(0, 64);
    step();

    // Asynchronous reset mid-stream at index 40
    load32();
    stream32(0, 40);
    #2 rst = 1'b1;
    #1;
    check("arst_w_valid", 64'(valid32), 64'd0);
    check("arst_w_data", 64'(data32), 64'd0);
    check("arst_w_idx", 64'(idx32), 64'd0);
    check("arst_blk_ready", 64'(blk_ready32), 64'd1);
    check("arst_busy", 64'(busy32), 64'd0);
    #1 rst = 1'b0;
    #1;
    check("arst_rel_w_valid", 64'(valid32), 64'd0);
    step();
    load32();
    stream32(0, 64);
    step();

    // Back-to-back with blk_valid held high
    blk_data32  = abc32;
    blk_valid32 = 1'b1;
    step();
    stream32(0, 64);
    check("b2b_gap_w_valid", 64'(valid32), 64'd0);
    check("b2b_gap_blk_ready", 64'(blk_ready32), 64'd1);
    step();
    check("b2b_second_load", 64'(valid32), 64'd1);
    stream32(0, 64);
    blk_valid32 = 1'b0;
    step();
    check("b2b_idle", 64'(valid32), 64'd0);

    // SHA-512 "abc"
    blk_data64  = abc64;
    blk_valid64 = 1'b1;
    step();
    blk_valid64 = 1'b0;
    ready64     = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 80; c++) begin
      if (valid64) begin
        check("w64_idx", 64'(idx64), 64'(cnt));
        check("w64_data", data64, m64[cnt]);
        check("w64_last", 64'(last64), 64'(cnt == 79));
        if (cnt == 16) check("w64_16_const", data64, 64'h6162638000000000);
        cnt++;
      end
      step();
    end
    ready64 = 1'b0;
    check("w64_count", 64'(cnt), 64'd80);
    check("w64_end_valid", 64'(valid64), 64'd0);
    check("w64_end_blk_ready", 64'(blk_ready64), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
